// File: rtl/typedefs_pkg.sv
// Shared types for the simplified RV32 core: instruction layout, ALU op select,
// the multi-cycle controller state and the decode constants used to classify instructions.
package typedefs_pkg;

    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLT = 3'b010;
    localparam logic [2:0] F3_XOR = 3'b100;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_SUB  = 7'b0100000;

    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instr_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT
    } aluop_sel_t;

    typedef enum logic [2:0] {
        FETCH,
        WAIT_RSP,
        DECODE,
        EXECUTE,
        WRITEBACK,
        HALT
    } ctrl_state_t;

    // OP and OP_IMM share the same funct3 subset; shifts (001/101) and SLTU (011) are not supported.
    function automatic logic funct3_supported(input logic [2:0] f3);
        return (f3 == F3_ADD) || (f3 == F3_SLT) || (f3 == F3_XOR) ||
               (f3 == F3_OR)  || (f3 == F3_AND);
    endfunction

    function automatic aluop_sel_t funct3_to_aluop(input logic [2:0] f3);
        aluop_sel_t op;
        case (f3)
            F3_SLT:  op = ALU_SLT;
            F3_XOR:  op = ALU_XOR;
            F3_OR:   op = ALU_OR;
            F3_AND:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational decoder for OP / OP_IMM: produces ALU select, operand-B mux,
// the sign-extended I-type immediate and a legality flag.
module instr_decoder
    import typedefs_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  instr_t            instr,
    output aluop_sel_t        alu_op,
    output logic              alu_src_imm,
    output logic [XLEN-1:0]   imm,
    output logic              legal
);

    assign imm = {{(XLEN-12){instr.funct7[6]}}, instr.funct7, instr.rs2};

    // Unsupported encodings leave alu_op at ADD so the datapath sees a benign select.
    always_comb begin
        alu_op      = ALU_ADD;
        alu_src_imm = 1'b0;
        legal       = 1'b0;
        case (instr.opcode)
            OP: begin
                if (funct3_supported(instr.funct3) &&
                    ((instr.funct7 == F7_BASE) ||
                     ((instr.funct3 == F3_ADD) && (instr.funct7 == F7_SUB)))) begin
                    legal  = 1'b1;
                    alu_op = (instr.funct7 == F7_SUB) ? ALU_SUB : funct3_to_aluop(instr.funct3);
                end
            end
            OP_IMM: begin
                alu_src_imm = 1'b1;
                if (funct3_supported(instr.funct3)) begin
                    legal  = 1'b1;
                    alu_op = funct3_to_aluop(instr.funct3);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: owns the PC, runs the instruction-memory handshake and
// steps each instruction through DECODE / EXECUTE / WRITEBACK, halting on illegal encodings.
module multicycle_ctrl
    import typedefs_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rdata,
    output logic [4:0]        rf_rs1_addr,
    output logic [4:0]        rf_rs2_addr,
    output aluop_sel_t        alu_op,
    output logic              alu_src_imm,
    output logic [XLEN-1:0]   imm,
    output logic              rf_we,
    output logic [4:0]        rf_rd_addr,
    output logic [XLEN-1:0]   pc,
    output logic              instr_retired,
    output logic [31:0]       retired_count,
    output logic              illegal_instr,
    output logic              halted
);

    ctrl_state_t state;
    ctrl_state_t state_next;
    instr_t      instr_q;
    logic        dec_legal;

    instr_decoder #(.XLEN(XLEN)) u_decoder (
        .instr       (instr_q),
        .alu_op      (alu_op),
        .alu_src_imm (alu_src_imm),
        .imm         (imm),
        .legal       (dec_legal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    // The instruction register only loads in WAIT_RSP, so responses seen in any other state are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_PC;
            instr_q       <= '0;
            retired_count <= '0;
        end else begin
            if ((state == WAIT_RSP) && imem_rsp_valid) begin
                instr_q <= instr_t'(imem_rdata);
            end
            if (state == WRITEBACK) begin
                pc            <= pc + XLEN'(4);
                retired_count <= retired_count + 32'd1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH:     if (imem_req_ready) state_next = WAIT_RSP;
            WAIT_RSP:  if (imem_rsp_valid) state_next = DECODE;
            DECODE:    state_next = dec_legal ? EXECUTE : HALT;
            EXECUTE:   state_next = WRITEBACK;
            WRITEBACK: state_next = FETCH;
            HALT:      state_next = HALT;
            default:   state_next = FETCH;
        endcase
    end

    always_comb begin
        imem_req_valid = 1'b0;
        rf_we          = 1'b0;
        instr_retired  = 1'b0;
        illegal_instr  = 1'b0;
        halted         = 1'b0;
        case (state)
            FETCH:     imem_req_valid = 1'b1;
            DECODE:    illegal_instr  = ~dec_legal;
            WRITEBACK: begin
                rf_we         = (instr_q.rd != 5'd0);
                instr_retired = 1'b1;
            end
            HALT:      halted = 1'b1;
            default: ;
        endcase
    end

    assign imem_addr   = pc;
    assign rf_rs1_addr = instr_q.rs1;
    assign rf_rs2_addr = instr_q.rs2;
    assign rf_rd_addr  = instr_q.rd;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the simplified RV32 core.
- Owns the PC and runs the instruction-memory handshake.
- Decodes OP and OP_IMM instructions into ALU op select, operand mux and register-file controls, one instruction at a time.
- Sits between instruction memory and the regfile/ALU datapath; stops in HALT on any unsupported encoding.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, width of PC, address and immediate.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous active-high reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_addr  out  XLEN  fetch address, always equals pc
- imem_rsp_valid  in  1  fetch data valid
- imem_rdata  in  32  fetched instruction (instr_t)
- rf_rs1_addr  out  5  regfile read port 1 address
- rf_rs2_addr  out  5  regfile read port 2 address
- alu_op  out  aluop_sel_t  ALU operation select
- alu_src_imm  out  1  1 = ALU operand B is imm, 0 = rs2 data
- imm  out  XLEN  sign-extended I-type immediate
- rf_we  out  1  regfile write enable
- rf_rd_addr  out  5  regfile write address
- pc  out  XLEN  current PC
- instr_retired  out  1  one-cycle pulse per completed instruction
- retired_count  out  32  count of retired instructions
- illegal_instr  out  1  one-cycle pulse on decode of unsupported encoding
- halted  out  1  high while in HALT

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values:
  - state=FETCH, pc=RESET_PC, instr register=0, retired_count=0.
  - All pulse and enable outputs 0; halted=0; alu_op=ADD; alu_src_imm=0.
- States: FETCH, WAIT_RSP, DECODE, EXECUTE, WRITEBACK, HALT.
- FETCH:
  - imem_req_valid=1, held until imem_req_ready=1 in the same cycle; then go to WAIT_RSP.
  - imem_rsp_valid is ignored in FETCH.
- WAIT_RSP:
  - imem_req_valid=0.
  - On imem_rsp_valid=1, latch imem_rdata into the instr register and go to DECODE; otherwise stay.
- DECODE: rs1/rs2 addresses driven from the latched instr; decoder evaluated.
  - Illegal encoding: illegal_instr=1 for this cycle, next state HALT.
  - Otherwise next state EXECUTE.
- EXECUTE: alu_op, alu_src_imm and imm valid; the datapath registers the ALU result at the end of this cycle.
- WRITEBACK:
  - rf_we=1 unless rd==0.
  - instr_retired=1 and retired_count+=1 (wraps modulo 2^32).
  - pc <= pc+4 (wraps modulo 2^XLEN).
  - Next state FETCH.
- HALT: sticky, halted=1, no requests issued, pc frozen; only rst exits.
- Output stability: rf_rs1_addr, rf_rs2_addr, rf_rd_addr, alu_op, alu_src_imm and imm are driven combinationally from the latched instr and are stable from DECODE through WRITEBACK.
- Latency: a minimum of 5 cycles per instruction (request accepted in FETCH, response in the next cycle).
- Decode table, opcode OP (0110011):
  - funct3=000: funct7 0000000 → ADD; funct7 0100000 → SUB.
  - funct7 must be 0000000 for: 111 AND, 110 OR, 100 XOR, 010 SLT.
  - Any other funct3/funct7 combination is illegal.
- Decode table, opcode OP_IMM (0010011):
  - 000 ADD, 111 AND, 110 OR, 100 XOR, 010 SLT.
  - alu_src_imm=1; imm = sign-extend(instr[31:20]).
  - funct3 001/011/101 is illegal.
- Any other opcode is illegal.
- rst mid-operation: asserted in any state (including WAIT_RSP), it restores reset values on the next edge. A late imem_rsp_valid from the aborted fetch arrives while in FETCH and is ignored.

Decomposition:
- Add to typedefs_pkg:
  - ctrl_state_t enum (FETCH, WAIT_RSP, DECODE, EXECUTE, WRITEBACK, HALT).
  - localparams F3_ADD=3'b000, F3_SLT=3'b010, F3_XOR=3'b100, F3_OR=3'b110, F3_AND=3'b111.
  - localparams F7_BASE=7'b0000000, F7_SUB=7'b0100000.
  - Reuse the existing instr_t, aluop_sel_t, OP and OP_IMM.
- Sub-module: instr_decoder, purely combinational.
  - Input: instr_t.
  - Outputs: aluop_sel_t, alu_src_imm, imm, legal.
  - Instantiated once inside multicycle_ctrl.

Test Plan:
- Reset, then 0x002081B3 (ADD x3,x1,x2), zero-wait memory:
  - imem_req_valid rises in cycle 0.
  - rf_rs1_addr=1, rf_rs2_addr=2, alu_op=ADD, alu_src_imm=0.
  - rf_we=1 with rf_rd_addr=3 exactly 4 cycles after request accept.
  - pc becomes 0x4; retired_count=1.
- 0xFFF00293 (ADDI x5,x0,-1):
  - alu_src_imm=1, imm=0xFFFFFFFF, alu_op=ADD, rf_rd_addr=5.
- 0x40208233 (SUB x4,x1,x2) then 0x0020A033 (SLT x0,x1,x2):
  - SUB decodes to alu_op=SUB.
  - SLT decodes to alu_op=SLT, rf_we stays 0 (rd=0) but instr_retired pulses.
  - retired_count=2; pc=0x8.
- Backpressure: imem_req_ready low for 3 cycles, then imem_rsp_valid delayed 2 cycles:
  - imem_req_valid held for 4 cycles, imem_addr stable.
  - Decode does not start until rsp_valid; no spurious rf_we.
- 0x00000000, then 0x00209033 (funct3 001):
  - illegal_instr pulses once, halted=1.
  - No further imem_req_valid over 20 cycles; pc unchanged.
  - rst returns pc to RESET_PC.
- rst asserted while in WAIT_RSP, then a stale rsp_valid arrives:
  - Next cycle: state FETCH, pc=RESET_PC, halted=0.
  - The stale response is not latched; the new fetch issues to address 0x0.
